// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions: control-word bit positions, write-back source
// select, opcode values, the opcode-to-control-word table and small helpers.
// Pure package, no timing or flow control of its own.
package decode_pkg;

  // Control-word layout
  localparam int CW_W            = 12;
  localparam int CW_ALU_BSEL     = 0;
  localparam int CW_IMM_SEL      = 1;
  localparam int CW_ALU_MODSEL   = 2;
  localparam int CW_JMP          = 3;
  localparam int CW_BRH          = 4;
  localparam int CW_PC_SEL_LO    = 5;
  localparam int CW_PC_SEL_HI    = 6;
  localparam int CW_MEM_WE       = 7;
  localparam int CW_MEM_REQ      = 8;
  localparam int CW_REG_WE       = 9;
  localparam int CW_REG_INSEL_LO = 10;
  localparam int CW_REG_INSEL_HI = 11;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Source of the register write-back value
  typedef enum logic [1:0] {
    INSEL_ALU       = 2'd0,
    INSEL_UPPER_IMM = 2'd1,
    INSEL_MEM       = 2'd2,
    INSEL_PC4       = 2'd3
  } reg_insel_t;

  // Opcode field, inst[28:26]
  typedef enum logic [2:0] {
    OP_ALU_RR = 3'd0,
    OP_ALU_RI = 3'd1,
    OP_LUI    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_BRANCH = 3'd5,
    OP_JAL    = 3'd6,
    OP_JALR   = 3'd7
  } opcode_t;

  // Opcode-to-control-word table
  function automatic ctrl_word_t decode_opcode(input logic [2:0] op);
    ctrl_word_t cw;
    cw = '0;
    case (opcode_t'(op))
      OP_ALU_RR: begin
        cw[CW_REG_WE] = 1'b1;
        cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO] = INSEL_ALU;
      end
      OP_ALU_RI: begin
        cw[CW_ALU_BSEL] = 1'b1;
        cw[CW_IMM_SEL]  = 1'b1;
        cw[CW_REG_WE]   = 1'b1;
        cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO] = INSEL_ALU;
      end
      OP_LUI: begin
        cw[CW_IMM_SEL] = 1'b1;
        cw[CW_REG_WE]  = 1'b1;
        cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO] = INSEL_UPPER_IMM;
      end
      OP_LOAD: begin
        cw[CW_ALU_BSEL] = 1'b1;
        cw[CW_IMM_SEL]  = 1'b1;
        cw[CW_MEM_REQ]  = 1'b1;
        cw[CW_REG_WE]   = 1'b1;
        cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO] = INSEL_MEM;
      end
      OP_STORE: begin
        cw[CW_ALU_BSEL] = 1'b1;
        cw[CW_IMM_SEL]  = 1'b1;
        cw[CW_MEM_WE]   = 1'b1;
        cw[CW_MEM_REQ]  = 1'b1;
      end
      OP_BRANCH: begin
        // compare mode in the ALU, PC takes the branch target when taken
        cw[CW_ALU_MODSEL] = 1'b1;
        cw[CW_BRH]        = 1'b1;
        cw[CW_PC_SEL_HI:CW_PC_SEL_LO] = 2'd1;
      end
      OP_JAL: begin
        cw[CW_JMP]    = 1'b1;
        cw[CW_PC_SEL_HI:CW_PC_SEL_LO] = 2'd2;
        cw[CW_REG_WE] = 1'b1;
        cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO] = INSEL_PC4;
      end
      OP_JALR: begin
        cw[CW_ALU_BSEL] = 1'b1;
        cw[CW_IMM_SEL]  = 1'b1;
        cw[CW_JMP]      = 1'b1;
        cw[CW_PC_SEL_HI:CW_PC_SEL_LO] = 2'd3;
        cw[CW_REG_WE]   = 1'b1;
        cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO] = INSEL_PC4;
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

  // A load writes the register file from memory; its result is late.
  function automatic logic is_load(input ctrl_word_t cw);
    return cw[CW_REG_WE] &&
           (reg_insel_t'(cw[CW_REG_INSEL_HI:CW_REG_INSEL_LO]) == INSEL_MEM);
  endfunction

  // True for a register address that is implemented and writable (not r0).
  function automatic logic addr_live(input logic [4:0] a, input int nregs);
    return (a != 5'd0) && (int'(a) < nregs);
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Bundle of the fetch-side, write-back and execute-side signals of the decode stage.
// master: fetch/write-back/execute environment; slave: the decode stage itself.
// No timing of its own; in_valid/in_ready and out_valid/out_ready are valid-ready pairs.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int IP_W = 30
);
  import decode_pkg::*;

  logic            clk_en;
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_in;
  logic [IP_W-1:0] ip_in;
  logic            invalid;
  logic            flush;
  // write-back port
  logic            reg_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] reg_din;
  // execute side
  logic            out_valid;
  logic            out_ready;
  ctrl_word_t      control_word;
  logic [31:0]     inst_out;
  logic [IP_W-1:0] ip_out;
  logic [XLEN-1:0] rs1_out;
  logic [XLEN-1:0] rs2_out;

  modport master (
    output clk_en, in_valid, inst_in, ip_in, invalid, flush,
    output reg_we, rd_addr, reg_din, out_ready,
    input  in_ready, out_valid, control_word, inst_out, ip_out, rs1_out, rs2_out
  );

  modport slave (
    input  clk_en, in_valid, inst_in, ip_in, invalid, flush,
    input  reg_we, rd_addr, reg_din, out_ready,
    output in_ready, out_valid, control_word, inst_out, ip_out, rs1_out, rs2_out
  );

endinterface

// File: rtl/decode_stage_pipe_scoreboard.sv
// Register scoreboard: one busy bit per register with an outstanding load.
// Set/clear take effect on the next enabled edge; lookups are combinational.
// No backpressure of its own; the decode stage turns busy hits into stalls.
// Ports: clk/rst/clk_en; set_en/set_addr (load leaving decode);
//        clr_en/clr_addr (write-back); rs1_addr/rs2_addr -> rs1_busy/rs2_busy.
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic       rs1_busy,
  output logic       rs2_busy
);

  // Full 32-entry vector; entries for r0 and unimplemented registers are
  // never set, so a lookup of those addresses always returns 0.
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_en) begin
      busy_nxt[clr_addr] = 1'b0;
    end
    // Applied after the clear: a load leaving decode to a register that is
    // being written back in the same cycle still owns that register.
    if (set_en && addr_live(set_addr, NREGS)) begin
      busy_nxt[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (clk_en) begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: opcode decode, register-file read, load-use interlock, registered output.
// Latency 1 cycle from in_valid&&in_ready to out_valid; one instruction per cycle.
// Backpressure: in_ready drops while output is held (out_ready=0), on a hazard or on flush.
// Ports: clk, rst (async, active-high); bus (decode_stage_pipe_if.slave) carrying
//        clk_en, fetch handshake + inst/ip/invalid, flush, write-back port and
//        execute handshake + control_word/inst/ip/rs1/rs2 payload.
// Option: DECODE_BYPASS_EN forwards a same-cycle write-back into rs1_out/rs2_out
//         instead of stalling one cycle.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IP_W  = 30,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  decode_stage_pipe_if.slave  bus
);

  // ---------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------
  logic [2:0] op;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] held_rd;

  assign op      = bus.inst_in[28:26];
  assign rs1     = bus.inst_in[25:21];
  assign rs2     = bus.inst_in[11:7];

  // Output registers
  logic            out_valid_q;
  ctrl_word_t      cw_q;
  logic [31:0]     inst_q;
  logic [IP_W-1:0] ip_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  assign held_rd = inst_q[20:16];

  // A bubble carries an all-zero control word so nothing downstream acts on it.
  ctrl_word_t dec_cw;
  assign dec_cw = bus.invalid ? '0 : decode_opcode(op);

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  // Sized for the full 5-bit address space; entries at or above NREGS are
  // never written, stay at their reset value and are trimmed by synthesis.
  logic [XLEN-1:0] regs [32];
  logic            wb_live;

  assign wb_live = bus.reg_we && addr_live(bus.rd_addr, NREGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.clk_en && wb_live) begin
      regs[bus.rd_addr] <= bus.reg_din;
    end
  end

  // Write-back landing on a source register in the current cycle
  logic wb_hit_rs1;
  logic wb_hit_rs2;
  assign wb_hit_rs1 = wb_live && (bus.rd_addr == rs1);
  assign wb_hit_rs2 = wb_live && (bus.rd_addr == rs2);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = addr_live(rs1, NREGS) ? regs[rs1] : '0;
    rs2_val = addr_live(rs2, NREGS) ? regs[rs2] : '0;
`ifdef DECODE_BYPASS_EN
    if (wb_hit_rs1) begin
      rs1_val = bus.reg_din;
    end
    if (wb_hit_rs2) begin
      rs2_val = bus.reg_din;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic busy_rs1;
  logic busy_rs2;
  logic held_load;
  logic held_hit;
  logic wb_stall;
  logic hazard;

  // A load sitting in the output register has not reached the scoreboard yet,
  // so its destination is checked directly.
  assign held_load = out_valid_q && is_load(cw_q);
  assign held_hit  = held_load && addr_live(held_rd, NREGS) &&
                     ((held_rd == rs1) || (held_rd == rs2));

`ifdef DECODE_BYPASS_EN
  assign wb_stall = 1'b0;
`else
  // Without forwarding the array read would return the stale value this
  // cycle; waiting one cycle lets the write land first.
  assign wb_stall = wb_hit_rs1 || wb_hit_rs2;
`endif

  assign hazard = bus.in_valid && !bus.invalid &&
                  (busy_rs1 || busy_rs2 || held_hit || wb_stall);

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  logic xfer_in;
  logic xfer_out;

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign xfer_in      = bus.in_valid && bus.in_ready && bus.clk_en;
  // A flushed instruction is never considered accepted downstream.
  assign xfer_out     = out_valid_q && bus.out_ready && !bus.flush && bus.clk_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      cw_q        <= '0;
      inst_q      <= '0;
      ip_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else if (bus.clk_en) begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (xfer_in) begin
        out_valid_q <= 1'b1;
        cw_q        <= dec_cw;
        inst_q      <= bus.inst_in;
        ip_q        <= bus.ip_in;
        rs1_q       <= rs1_val;
        rs2_q       <= rs2_val;
      end else if (xfer_out) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.control_word = cw_q;
  assign bus.inst_out     = inst_q;
  assign bus.ip_out       = ip_q;
  assign bus.rs1_out      = rs1_q;
  assign bus.rs2_out      = rs2_q;

  // ---------------------------------------------------------------------
  // Scoreboard: a load becomes outstanding when execute takes it
  // ---------------------------------------------------------------------
  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (bus.clk_en),
    .set_en   (xfer_out && held_load),
    .set_addr (held_rd),
    .clr_en   (bus.reg_we),
    .clr_addr (bus.rd_addr),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_busy (busy_rs1),
    .rs2_busy (busy_rs2)
  );

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  localparam int XLEN  = 32;
  localparam int IP_W  = 30;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(XLEN), .IP_W(IP_W)) bus ();

  decode_stage_pipe #(
    .XLEN  (XLEN),
    .IP_W  (IP_W),
    .NREGS (NREGS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected control words per opcode, bit layout:
  // 0 BSEL,1 IMM,2 MOD,3 JMP,4 BRH,6:5 PC_SEL,7 MEM_WE,8 MEM_REQ,9 REG_WE,11:10 INSEL
  localparam logic [11:0] EXP_CW [8] = '{
    12'h200,  // ALU reg-reg
    12'h203,  // ALU imm
    12'h602,  // LUI
    12'hB03,  // LOAD
    12'h183,  // STORE
    12'h034,  // BRANCH
    12'hE48,  // JAL
    12'hE6B   // JALR
  };

  typedef struct {
    logic [11:0]     cw;
    logic [31:0]     inst;
    logic [IP_W-1:0] ip;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } exp_t;

  exp_t            sbq[$];
  logic [XLEN-1:0] model [32];
  logic [IP_W-1:0] ip_ctr;
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {3'b000, 3'(op), 5'(rs1), 5'(rd), 4'b0000, 5'(rs2), 7'b0000000};
  endfunction

  // Reference register read as seen by an instruction accepted this cycle
  function automatic logic [XLEN-1:0] ref_read(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = (a == 5'd0) ? '0 : model[a];
`ifdef DECODE_BYPASS_EN
    if (bus.reg_we && a != 5'd0 && bus.rd_addr == a) v = bus.reg_din;
`endif
    return v;
  endfunction

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input logic inv);
    bus.in_valid = 1'b1;
    bus.inst_in  = mk(op, rd, rs1, rs2);
    bus.ip_in    = ip_ctr;
    bus.invalid  = inv;
    ip_ctr       = ip_ctr + 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.invalid  = 1'b0;
  endtask

  task automatic wb(input int a, input logic [XLEN-1:0] d);
    bus.reg_we  = 1'b1;
    bus.rd_addr = 5'(a);
    bus.reg_din = d;
  endtask

  // Called right after a falling edge: samples handshakes mid-low-phase,
  // updates the scoreboard and reference model, then waits for the next
  // falling edge.
  task automatic tick();
    exp_t e;
    logic [2:0] opf;
    #1;
    if (!rst && bus.clk_en) begin
      if (bus.out_valid && bus.flush) begin
        if (sbq.size() > 0) e = sbq.pop_front();
      end else if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (sbq.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=empty expected=pending_entry");
        end
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("out_cw",   bus.control_word, e.cw);
          check("out_inst", bus.inst_out,     e.inst);
          check("out_ip",   bus.ip_out,       e.ip);
          check("out_rs1",  bus.rs1_out,      e.rs1);
          check("out_rs2",  bus.rs2_out,      e.rs2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        opf    = bus.inst_in[28:26];
        e.cw   = bus.invalid ? 12'h000 : EXP_CW[opf];
        e.inst = bus.inst_in;
        e.ip   = bus.ip_in;
        e.rs1  = ref_read(bus.inst_in[25:21]);
        e.rs2  = ref_read(bus.inst_in[11:7]);
        sbq.push_back(e);
      end
      if (bus.reg_we && bus.rd_addr != 5'd0) model[bus.rd_addr] = bus.reg_din;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ip_ctr = '0;
    bus.clk_en = 1'b1;  bus.in_valid = 1'b0; bus.inst_in = '0; bus.ip_in = '0;
    bus.invalid = 1'b0; bus.flush = 1'b0;    bus.reg_we = 1'b0; bus.rd_addr = '0;
    bus.reg_din = '0;   bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_cw", bus.control_word, 0);
    check("rst_inst_out", bus.inst_out, 0);
    check("rst_rs1_out", bus.rs1_out, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Seed registers; the write to r0 must be ignored
    wb(1, 32'h1111_1111); tick();
    wb(2, 32'h2222_2222); tick();
    wb(0, 32'hFFFF_FFFF); tick();
    bus.reg_we = 1'b0;

    // All opcodes back-to-back at full rate
    for (int op = 0; op < 8; op++) begin
      send(op, 16 + op, 1, 2, 1'b0);
      #1; check("stream_rdy", bus.in_ready, 1);
      tick();
    end
    idle(); tick();

    // Backpressure: payload held, in_ready low, next appears one cycle after release
    send(1, 4, 1, 2, 1'b0); tick();
    bus.out_ready = 1'b0;
    send(2, 6, 2, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_rdy", bus.in_ready, 0);
      check("bp_hold", bus.inst_out, mk(1, 4, 1, 2));
      tick();
    end
    bus.out_ready = 1'b1;
    #1; check("bp_release_rdy", bus.in_ready, 1);
    tick();
    idle();
    #1; check("bp_next_inst", bus.inst_out, mk(2, 6, 2, 1));
    check("bp_next_valid", bus.out_valid, 1);
    tick();

    // Load-use on r5
    send(3, 5, 1, 2, 1'b0); tick();
    send(0, 6, 5, 2, 1'b0);
    #1; check("lu_held_stall", bus.in_ready, 0);
    tick();
    #1; check("lu_busy_stall", bus.in_ready, 0);
    tick();
    wb(5, 32'hDEAD_BEEF);
    #1; check("lu_wb_stall", bus.in_ready, 0);
    tick();
    bus.reg_we = 1'b0;
    #1; check("lu_release", bus.in_ready, 1);
    tick();
    idle();
    #1; check("lu_rs1", bus.rs1_out, 32'hDEAD_BEEF);
    tick();

    // Same-cycle write-back to a source register
    send(0, 8, 1, 3, 1'b0);
    wb(3, 32'h0000_1234);
    #1;
`ifdef DECODE_BYPASS_EN
    check("byp_no_stall", bus.in_ready, 1);
`else
    check("byp_stall", bus.in_ready, 0);
`endif
    tick();
    bus.reg_we = 1'b0;
`ifndef DECODE_BYPASS_EN
    #1; check("byp_retry_rdy", bus.in_ready, 1);
    tick();
`endif
    idle();
    #1; check("byp_rs2", bus.rs2_out, 32'h0000_1234);
    tick();

    // Flush of a held load to r7 while execute is ready
    send(3, 7, 1, 2, 1'b0); tick();
    idle(); bus.flush = 1'b1;
    #1; check("flush_rdy", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    #1; check("flush_valid", bus.out_valid, 0);
    send(0, 9, 7, 1, 1'b0);
    #1; check("flush_no_stall", bus.in_ready, 1);
    tick();
    idle(); tick();

    // Bubble with a load encoding: zero control word, no busy bit
    send(3, 12, 1, 2, 1'b1);
    #1; check("bub_rdy", bus.in_ready, 1);
    tick();
    #1; check("bub_cw", bus.control_word, 0);
    check("bub_valid", bus.out_valid, 1);
    send(0, 13, 12, 12, 1'b0);
    #1; check("bub_no_stall1", bus.in_ready, 1);
    tick();
    send(0, 14, 12, 12, 1'b0);
    #1; check("bub_no_stall2", bus.in_ready, 1);
    tick();
    // r0 reads zero despite the earlier write
    send(0, 15, 0, 0, 1'b0); tick();
    idle();
    #1; check("r0_rs1", bus.rs1_out, 0);
    check("r0_rs2", bus.rs2_out, 0);
    tick();

    // clk_en low: no state change, write-back ignored
    send(0, 21, 1, 2, 1'b0); tick();
    bus.clk_en = 1'b0;
    send(0, 22, 20, 2, 1'b0);
    wb(20, 32'hCAFE_0000);
    tick();
    #1; check("cen_valid", bus.out_valid, 1);
    check("cen_hold", bus.inst_out, mk(0, 21, 1, 2));
    bus.clk_en = 1'b1; bus.reg_we = 1'b0;
    #1; check("cen_rdy", bus.in_ready, 1);
    tick();
    idle();
    #1; check("cen_no_write", bus.rs1_out, 0);
    tick();

    // Reset mid-stream with a held instruction
    send(0, 23, 1, 2, 1'b0); tick();
    bus.out_ready = 1'b0;
    send(0, 24, 1, 2, 1'b0);
    rst = 1'b1;
    #1; check("mrst_valid", bus.out_valid, 0);
    check("mrst_cw", bus.control_word, 0);
    sbq.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    tick();
    rst = 1'b0;
    #1; check("mrst_rdy", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    idle();
    #1; check("mrst_out_valid", bus.out_valid, 1);
    check("mrst_regs_cleared", bus.rs1_out, 0);
    tick();

    repeat (2) tick();
    check("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
